// File: rtl/eth_rx_frame_recorder_pkg.sv
// Shared constants for the Ethernet receive frame recorder: byte width,
// default maximum frame length and FSM state encodings.
package eth_rx_frame_recorder_pkg;

   localparam int unsigned BYTE_LEN          = 8;
   localparam int unsigned MAX_ETH_FRAME_LEN = 1522;
   localparam int unsigned DROP_W            = 16;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_RECORD  = 2'd1;
   localparam logic [1:0] ST_DISCARD = 2'd2;
   localparam logic [1:0] ST_HALT    = 2'd3;

endpackage

// File: rtl/eth_rx_frame_recorder_desc_ring.sv
// Descriptor FIFO for stored frames plus slot ownership accounting:
// slots are claimed by the writer, handed out in order and returned in order.
module eth_rx_frame_recorder_desc_ring #(
   parameter  int unsigned NUM_SLOTS = 4,
   parameter  int unsigned LEN_W     = 11,
   localparam int unsigned SLOT_W    = $clog2(NUM_SLOTS),
   localparam int unsigned CNT_W     = SLOT_W + 1
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              claim,
   input  logic              push,
   input  logic [SLOT_W-1:0] push_slot,
   input  logic [LEN_W-1:0]  push_len,
   input  logic              push_trunc,
   input  logic              desc_ready,
   input  logic              release_req,
   output logic              desc_valid,
   output logic [SLOT_W-1:0] desc_slot,
   output logic [LEN_W-1:0]  desc_len,
   output logic              desc_trunc,
   output logic [CNT_W-1:0]  free_cnt,
   output logic              rel_ok_c
);

   logic [SLOT_W-1:0]    q_slot [NUM_SLOTS];
   logic [LEN_W-1:0]     q_len  [NUM_SLOTS];
   logic [NUM_SLOTS-1:0] q_trunc;
   logic [SLOT_W-1:0]    wr_ptr;
   logic [SLOT_W-1:0]    rd_ptr;
   logic [CNT_W-1:0]     q_cnt;
   logic [CNT_W-1:0]     acc_cnt;
   logic                 pop_c;

   // A release only counts when some accepted slot is still outstanding
   assign pop_c    = (q_cnt != '0) && desc_ready;
   assign rel_ok_c = release_req && (acc_cnt != '0);

   always_ff @(posedge clk) begin
      if (!rstn) begin
         for (int unsigned i = 0; i < NUM_SLOTS; i++) begin
            q_slot[i] <= '0;
            q_len[i]  <= '0;
         end
         q_trunc  <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         q_cnt    <= '0;
         acc_cnt  <= '0;
         free_cnt <= CNT_W'(NUM_SLOTS);
      end else begin
         if (push) begin
            q_slot[wr_ptr]  <= push_slot;
            q_len[wr_ptr]   <= push_len;
            q_trunc[wr_ptr] <= push_trunc;
            wr_ptr          <= wr_ptr + SLOT_W'(1);
         end
         if (pop_c) begin
            rd_ptr <= rd_ptr + SLOT_W'(1);
         end
         q_cnt    <= q_cnt + CNT_W'(push) - CNT_W'(pop_c);
         acc_cnt  <= acc_cnt + CNT_W'(pop_c) - CNT_W'(rel_ok_c);
         free_cnt <= free_cnt + CNT_W'(rel_ok_c) - CNT_W'(claim);
      end
   end

   assign desc_valid = (q_cnt != '0);
   assign desc_slot  = q_slot[rd_ptr];
   assign desc_len   = q_len[rd_ptr];
   assign desc_trunc = q_trunc[rd_ptr];

endmodule

// File: rtl/eth_rx_frame_recorder.sv
// Records received Ethernet frames into a ring of fixed-size packet RAM slots
// and publishes one descriptor per stored frame; frames without a slot are dropped.
module eth_rx_frame_recorder
   import eth_rx_frame_recorder_pkg::*;
#(
   parameter  int unsigned NUM_SLOTS     = 4,
   parameter  int unsigned SLOT_SIZE     = 2048,
   parameter  int unsigned MAX_FRAME_LEN = MAX_ETH_FRAME_LEN,
   parameter  int unsigned ONE_SHOT      = 0,
   localparam int unsigned SLOT_W        = $clog2(NUM_SLOTS),
   localparam int unsigned OFF_W         = $clog2(SLOT_SIZE),
   localparam int unsigned ADDR_W        = $clog2(NUM_SLOTS * SLOT_SIZE),
   localparam int unsigned LEN_W         = $clog2(MAX_FRAME_LEN + 1)
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic                inclk,
   input  logic [BYTE_LEN-1:0] in,
   input  logic                in_done,
   output logic                ram_we,
   output logic [ADDR_W-1:0]   ram_waddr,
   output logic [BYTE_LEN-1:0] ram_win,
   output logic                desc_valid,
   input  logic                desc_ready,
   output logic [SLOT_W-1:0]   desc_slot,
   output logic [LEN_W-1:0]    desc_len,
   output logic                desc_trunc,
   input  logic                release_req,
   output logic [SLOT_W:0]     free_cnt,
   output logic [DROP_W-1:0]   drop_cnt,
   output logic                busy
);

   localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_FRAME_LEN);

   logic [1:0]          state,       state_nxt;
   logic [LEN_W-1:0]    cnt,         cnt_nxt;
   logic                trunc,       trunc_nxt;
   logic [SLOT_W-1:0]   wr_slot,     wr_slot_nxt;
   logic                we_nxt;
   logic [ADDR_W-1:0]   waddr_nxt;
   logic [BYTE_LEN-1:0] win_nxt;
   logic [DROP_W-1:0]   drop_nxt;
   logic                busy_nxt;
   logic                claim_c;
   logic                commit_c;
   logic                drop_c;
   logic [LEN_W-1:0]    push_len_c;
   logic                push_trunc_c;
   logic                rel_ok_c;

   eth_rx_frame_recorder_desc_ring #(
      .NUM_SLOTS (NUM_SLOTS),
      .LEN_W     (LEN_W)
   ) u_ring (
      .clk         (clk),
      .rstn        (rstn),
      .claim       (claim_c),
      .push        (commit_c),
      .push_slot   (wr_slot),
      .push_len    (push_len_c),
      .push_trunc  (push_trunc_c),
      .desc_ready  (desc_ready),
      .release_req (release_req),
      .desc_valid  (desc_valid),
      .desc_slot   (desc_slot),
      .desc_len    (desc_len),
      .desc_trunc  (desc_trunc),
      .free_cnt    (free_cnt),
      .rel_ok_c    (rel_ok_c)
   );

   // State, byte counter and registered RAM write port
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state     <= ST_IDLE;
         cnt       <= '0;
         trunc     <= 1'b0;
         wr_slot   <= '0;
         ram_we    <= 1'b0;
         ram_waddr <= '0;
         ram_win   <= '0;
         drop_cnt  <= '0;
         busy      <= 1'b0;
      end else begin
         state     <= state_nxt;
         cnt       <= cnt_nxt;
         trunc     <= trunc_nxt;
         wr_slot   <= wr_slot_nxt;
         ram_we    <= we_nxt;
         ram_waddr <= waddr_nxt;
         ram_win   <= win_nxt;
         drop_cnt  <= drop_nxt;
         busy      <= busy_nxt;
      end
   end

   // Next-state and write decisions; a slot freed this cycle may be claimed at once
   always_comb begin
      state_nxt    = state;
      cnt_nxt      = cnt;
      trunc_nxt    = trunc;
      wr_slot_nxt  = wr_slot;
      we_nxt       = 1'b0;
      waddr_nxt    = ram_waddr;
      win_nxt      = ram_win;
      drop_nxt     = drop_cnt;
      claim_c      = 1'b0;
      commit_c     = 1'b0;
      drop_c       = 1'b0;
      push_len_c   = '0;
      push_trunc_c = 1'b0;

      case (state)
         ST_IDLE: begin
            if (inclk) begin
               if ((free_cnt != '0) || rel_ok_c) begin
                  claim_c   = 1'b1;
                  we_nxt    = 1'b1;
                  waddr_nxt = ADDR_W'({wr_slot, {OFF_W{1'b0}}});
                  win_nxt   = in;
                  cnt_nxt   = LEN_W'(1);
                  trunc_nxt = 1'b0;
                  state_nxt = ST_RECORD;
                  commit_c  = in_done;
               end else begin
                  state_nxt = ST_DISCARD;
                  drop_c    = in_done;
               end
            end
         end
         ST_RECORD: begin
            if (inclk) begin
               if (cnt < MAX_LEN) begin
                  we_nxt    = 1'b1;
                  waddr_nxt = ADDR_W'({wr_slot, OFF_W'(cnt)});
                  win_nxt   = in;
                  cnt_nxt   = cnt + LEN_W'(1);
               end else begin
                  trunc_nxt = 1'b1;
               end
            end
            commit_c = in_done;
         end
         ST_DISCARD: begin
            drop_c = in_done;
         end
         default: begin
         end
      endcase

      // The final byte of a frame is counted before the descriptor is built
      if (commit_c) begin
         push_len_c   = cnt_nxt;
         push_trunc_c = trunc_nxt;
         wr_slot_nxt  = wr_slot + SLOT_W'(1);
         cnt_nxt      = '0;
         trunc_nxt    = 1'b0;
         state_nxt    = (ONE_SHOT != 0) ? ST_HALT : ST_IDLE;
      end
      if (drop_c) begin
         drop_nxt  = (drop_cnt == '1) ? drop_cnt : drop_cnt + DROP_W'(1);
         state_nxt = ST_IDLE;
      end

      busy_nxt = (state_nxt == ST_RECORD) || (state_nxt == ST_DISCARD);
   end

endmodule

// File: tb/tb_eth_rx_frame_recorder.sv
// Bench for eth_rx_frame_recorder: directed frame table, corner-case sequences
// and randomized frames checked against a slot-accounting reference model.
module tb_eth_rx_frame_recorder;

   localparam int NS   = 4;
   localparam int MAXL = 1522;
   localparam int SS   = 2048;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rstn, inclk, in_done, desc_ready, release_req;
   logic [7:0]  in_b;

   logic        ram_we, desc_valid, desc_trunc, busy;
   logic [12:0] ram_waddr;
   logic [7:0]  ram_win;
   logic [1:0]  desc_slot;
   logic [10:0] desc_len;
   logic [2:0]  free_cnt;
   logic [15:0] drop_cnt;

   logic        os_ram_we, os_desc_valid, os_desc_trunc, os_busy;
   logic [12:0] os_ram_waddr;
   logic [7:0]  os_ram_win;
   logic [1:0]  os_desc_slot;
   logic [10:0] os_desc_len;
   logic [2:0]  os_free_cnt;
   logic [15:0] os_drop_cnt;

   eth_rx_frame_recorder #(.NUM_SLOTS(NS), .SLOT_SIZE(SS), .MAX_FRAME_LEN(MAXL), .ONE_SHOT(0)) dut (
      .clk(clk), .rstn(rstn), .inclk(inclk), .in(in_b), .in_done(in_done),
      .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_win(ram_win),
      .desc_valid(desc_valid), .desc_ready(desc_ready), .desc_slot(desc_slot),
      .desc_len(desc_len), .desc_trunc(desc_trunc), .release_req(release_req),
      .free_cnt(free_cnt), .drop_cnt(drop_cnt), .busy(busy));

   eth_rx_frame_recorder #(.NUM_SLOTS(NS), .SLOT_SIZE(SS), .MAX_FRAME_LEN(MAXL), .ONE_SHOT(1)) dut_os (
      .clk(clk), .rstn(rstn), .inclk(inclk), .in(in_b), .in_done(in_done),
      .ram_we(os_ram_we), .ram_waddr(os_ram_waddr), .ram_win(os_ram_win),
      .desc_valid(os_desc_valid), .desc_ready(desc_ready), .desc_slot(os_desc_slot),
      .desc_len(os_desc_len), .desc_trunc(os_desc_trunc), .release_req(release_req),
      .free_cnt(os_free_cnt), .drop_cnt(os_drop_cnt), .busy(os_busy));

   typedef struct packed {
      logic [1:0]  slot;
      logic [10:0] len;
      logic        trunc;
   } desc_t;

   typedef struct {
      int len;
      int slot;
      int dlen;
      bit trunc;
      bit stored;
      bit busy_m;
      int free_a;
      int drop_a;
   } vec_t;

   desc_t       dq[$];
   desc_t       eq[$];
   logic [12:0] wq_a[$];
   logic [7:0]  wq_d[$];
   int          os_wr_n = 0;
   int          os_desc_n = 0;
   int          n_tests = 0;
   int          n_fail = 0;
   logic [7:0]  fbytes [0:1599];
   logic        busy_mid;
   logic [2:0]  free_mid;
   vec_t        vt [6];

   // reference model of slot ownership
   int m_pend, m_acc, m_slot, m_drop;

   // Observe RAM writes and descriptor transfers away from the clock edge
   always @(negedge clk) begin
      if (ram_we) begin
         wq_a.push_back(ram_waddr);
         wq_d.push_back(ram_win);
      end
      if (desc_valid && desc_ready) dq.push_back({desc_slot, desc_len, desc_trunc});
      if (os_ram_we) os_wr_n++;
      if (os_desc_valid && desc_ready) os_desc_n++;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic tick_n(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
      end
   endtask

   task automatic send_frame(input int len, input bit rel_first);
      for (int i = 0; i < len; i++) begin
         fbytes[i]   = 8'($urandom);
         inclk       = 1'b1;
         in_b        = fbytes[i];
         in_done     = (i == len - 1);
         release_req = rel_first && (i == 0);
         tick();
         if (i == 0) begin
            busy_mid = busy;
            free_mid = free_cnt;
         end
      end
      inclk       = 1'b0;
      in_done     = 1'b0;
      release_req = 1'b0;
   endtask

   task automatic check_writes(input string nm, input int slot, input int n);
      int errs;
      int got;
      errs = 0;
      got  = wq_a.size();
      check({nm, "_wcnt"}, 32'(got), 32'(n));
      for (int i = 0; i < got && i < n; i++)
         if (int'(wq_a[i]) != slot * SS + i || wq_d[i] !== fbytes[i]) errs++;
      if (n > 0) check({nm, "_wdata"}, 32'(errs), 32'd0);
      wq_a.delete();
      wq_d.delete();
   endtask

   task automatic cmp_desc(input string nm);
      desc_t g;
      while (dq.size() > 0) begin
         g = dq.pop_front();
         if (eq.size() == 0) check({nm, "_extra"}, 32'(g), 32'hFFFF_FFFF);
         else                check(nm, 32'(g), 32'(eq.pop_front()));
      end
      check({nm, "_left"}, 32'(eq.size()), 32'd0);
      eq.delete();
   endtask

   function automatic desc_t mk_desc(input int slot, input int len, input bit tr);
      desc_t d;
      d.slot  = 2'(slot);
      d.len   = 11'(len);
      d.trunc = tr;
      return d;
   endfunction

   initial begin
      int len, dlen, this_slot, os_bw, os_bd;
      bit rdy, relf, rel_valid, stored;

      rstn = 1'b0; inclk = 1'b0; in_done = 1'b0; in_b = '0;
      desc_ready = 1'b0; release_req = 1'b0;

      //           len   slot dlen  tr st bm free drop
      vt[0] = '{  60,  0,   60,  0, 1, 1, 3, 0};
      vt[1] = '{1600,  1, 1522,  1, 1, 1, 2, 0};
      vt[2] = '{   1,  2,    1,  0, 1, 0, 1, 0};
      vt[3] = '{1522,  3, 1522,  0, 1, 1, 0, 0};
      vt[4] = '{  70,  0,    0,  0, 0, 1, 0, 1};
      vt[5] = '{   5,  0,    0,  0, 0, 1, 0, 2};

      tick_n(3);
      check("rst_we",    ram_we,      0);
      check("rst_dv",    desc_valid,  0);
      check("rst_free",  free_cnt,    NS);
      check("rst_drop",  drop_cnt,    0);
      check("rst_busy",  busy,        0);
      check("rst_waddr", ram_waddr,   0);
      check("rst_osfree", os_free_cnt, NS);
      rstn = 1'b1;
      tick_n(2);
      wq_a.delete(); wq_d.delete();

      // Directed table: fill every slot with no consumer, then overflow
      for (int k = 0; k < 6; k++) begin
         send_frame(vt[k].len, 1'b0);
         tick_n(3);
         check($sformatf("t%0d_busy_mid", k), busy_mid, vt[k].busy_m);
         check($sformatf("t%0d_free", k), free_cnt, vt[k].free_a);
         check($sformatf("t%0d_drop", k), drop_cnt, vt[k].drop_a);
         check($sformatf("t%0d_busy_end", k), busy, 0);
         if (vt[k].stored) begin
            check_writes($sformatf("t%0d", k), vt[k].slot, vt[k].dlen);
            eq.push_back(mk_desc(vt[k].slot, vt[k].dlen, vt[k].trunc));
         end else begin
            check_writes($sformatf("t%0d", k), 0, 0);
         end
      end
      check("hold_dv",    desc_valid, 1);
      check("hold_slot",  desc_slot,  0);
      check("hold_len",   desc_len,   60);
      check("hold_trunc", desc_trunc, 0);
      desc_ready = 1'b1;
      tick_n(8);
      desc_ready = 1'b0;
      tick();
      cmp_desc("tbl_desc");
      check("drained_dv",   desc_valid, 0);
      check("drained_free", free_cnt,   0);

      // Release coinciding with the first byte of a frame when no slot is free
      send_frame(50, 1'b1);
      tick_n(3);
      check("relsame_free_mid", free_mid, 0);
      check("relsame_free",     free_cnt, 0);
      check("relsame_drop",     drop_cnt, 2);
      check_writes("relsame", 0, 50);
      check("relsame_dv",   desc_valid, 1);
      check("relsame_slot", desc_slot,  0);
      check("relsame_len",  desc_len,   50);

      // Reset in the middle of a frame
      for (int i = 0; i < 10; i++) begin
         inclk = 1'b1; in_b = 8'(i); in_done = 1'b0;
         tick();
      end
      inclk = 1'b0;
      rstn  = 1'b0;
      tick();
      check("midrst_we",   ram_we,     0);
      check("midrst_busy", busy,       0);
      check("midrst_dv",   desc_valid, 0);
      check("midrst_free", free_cnt,   NS);
      check("midrst_drop", drop_cnt,   0);
      rstn = 1'b1;
      tick_n(3);
      check("postrst_dv", desc_valid, 0);
      wq_a.delete(); wq_d.delete(); dq.delete();

      // ONE_SHOT instance keeps only the first frame after reset
      os_bw = os_wr_n;
      os_bd = os_desc_n;
      desc_ready = 1'b1;
      send_frame(30, 1'b0);
      tick_n(6);
      send_frame(40, 1'b0);
      tick_n(6);
      check("os_writes", 32'(os_wr_n - os_bw), 30);
      check("os_descs",  32'(os_desc_n - os_bd), 1);
      check("os_busy",   os_busy, 0);
      check("os_drop",   os_drop_cnt, 0);
      check("os_free",   os_free_cnt, NS - 1);
      check("both_wcnt", 32'(wq_a.size()), 70);
      eq.push_back(mk_desc(0, 30, 0));
      eq.push_back(mk_desc(1, 40, 0));
      cmp_desc("both_desc");
      wq_a.delete(); wq_d.delete();

      // Randomized frames against the slot-accounting model
      desc_ready = 1'b0;
      rstn = 1'b0;
      tick();
      rstn = 1'b1;
      tick();
      wq_a.delete(); wq_d.delete(); dq.delete(); eq.delete();
      m_pend = 0; m_acc = 0; m_slot = 0; m_drop = 0;
      check("rnd_rst_free", free_cnt, NS);
      check("rnd_rst_drop", drop_cnt, 0);

      for (int it = 0; it < 40; it++) begin
         rdy  = 1'($urandom_range(0, 1));
         relf = ($urandom_range(0, 3) == 0);
         len  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1515, 1530))
                                            : int'($urandom_range(1, 64));
         rel_valid = relf && (m_acc > 0);
         stored    = (NS - m_pend - m_acc > 0) || rel_valid;
         if (rel_valid) m_acc--;
         dlen = (len > MAXL) ? MAXL : len;
         this_slot = m_slot;
         if (stored) begin
            eq.push_back(mk_desc(m_slot, dlen, len > MAXL));
            m_pend++;
            m_slot = (m_slot + 1) % NS;
         end else begin
            m_drop++;
         end
         desc_ready = rdy;
         send_frame(len, relf);
         tick_n(6);
         if (rdy) begin
            m_acc += m_pend;
            m_pend = 0;
         end
         check_writes($sformatf("r%0d", it), this_slot, stored ? dlen : 0);
         if ($urandom_range(0, 3) != 0) begin
            release_req = 1'b1;
            tick();
            release_req = 1'b0;
            if (m_acc > 0) m_acc--;
         end
         tick();
         check($sformatf("r%0d_free", it), free_cnt, NS - m_pend - m_acc);
         check($sformatf("r%0d_drop", it), drop_cnt, m_drop);
         check($sformatf("r%0d_busy", it), busy, 0);
         while (dq.size() > 0 && eq.size() > 0)
            check($sformatf("r%0d_desc", it), 32'(dq.pop_front()), 32'(eq.pop_front()));
      end
      desc_ready = 1'b1;
      tick_n(8);
      desc_ready = 1'b0;
      m_acc += m_pend;
      m_pend = 0;
      tick();
      cmp_desc("rnd_final_desc");
      check("rnd_final_free", free_cnt, NS - m_acc);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
